// File: rtl/fp_result_queue_if.sv
// Result types and the FP-unit / writeback handshake bundle for fp_result_queue.
package fp_result_queue_pkg;
  localparam int TAG_W = 7;
  localparam int SQN_W = 7;
  localparam int FLG_W = 4;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tagDst;
    logic [SQN_W-1:0] sqN;
    logic [31:0]      result;
    logic [FLG_W-1:0] flags;
    logic             doNotCommit;
  } RES_UOp;

  typedef struct packed {
    logic             taken;
    logic [SQN_W-1:0] sqN;
  } BranchProv;
endpackage

interface fp_result_queue_if;
  import fp_result_queue_pkg::*;
  BranchProv IN_branch;
  RES_UOp    IN_uopA;
  RES_UOp    IN_uopB;
  logic      IN_ready;
  RES_UOp    OUT_uop;
  logic      OUT_stall;

  modport master (output IN_branch, IN_uopA, IN_uopB, IN_ready, input OUT_uop, OUT_stall);
  modport slave  (input IN_branch, IN_uopA, IN_uopB, IN_ready, output OUT_uop, OUT_stall);
endinterface

// File: rtl/fp_result_queue.sv
// Merges FP mul (A) and div/sqrt (B) results into one in-order writeback stream with branch squash.
// Optional same-cycle bypass when empty: define FRQ_BYPASS_EN.
module fp_result_queue
  import fp_result_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst,
  fp_result_queue_if.slave bus
);
  localparam int PW = $clog2(DEPTH);

  // Stored valid field doubles as the per-entry squash bit.
  RES_UOp        r_mem [DEPTH];
  logic [PW-1:0] r_head, r_tail;
  logic [PW:0]   r_count;

  RES_UOp        w_head, w_out;
  logic          w_outVld, w_pop, w_reqA, w_reqB, w_wrA, w_wrB;
  logic [PW+1:0] w_room;
  logic [PW-1:0] w_tailB;
  logic [PW:0]   w_free;

  function automatic logic younger(logic [SQN_W-1:0] sq, BranchProv br);
    logic [SQN_W-1:0] d;
    d = sq - br.sqN;
    return br.taken && !d[SQN_W-1] && (d != '0);
  endfunction

  always_comb begin
    w_head   = r_mem[r_head];
    w_out    = w_head;
    w_reqA   = bus.IN_uopA.valid && !younger(bus.IN_uopA.sqN, bus.IN_branch);
    w_reqB   = bus.IN_uopB.valid && !younger(bus.IN_uopB.sqN, bus.IN_branch);
    w_outVld = (r_count != '0) && w_head.valid && !younger(w_head.sqN, bus.IN_branch);
    // A stale (squashed) head is dropped without occupying the bus.
    w_pop    = (r_count != '0) && ((w_outVld && bus.IN_ready) || !w_head.valid);
`ifdef FRQ_BYPASS_EN
    if ((r_count == '0) && (w_reqA || w_reqB)) begin
      w_out    = w_reqA ? bus.IN_uopA : bus.IN_uopB;
      w_outVld = 1'b1;
      if (bus.IN_ready) begin
        if (w_reqA) w_reqA = 1'b0;
        else        w_reqB = 1'b0;
      end
    end
`endif
    w_out.valid = w_outVld;
    w_room  = (PW+2)'(DEPTH) - (PW+2)'(r_count) + (PW+2)'(w_pop);
    w_wrA   = w_reqA && (w_room != '0);
    w_wrB   = w_reqB && (w_room > (PW+2)'(w_wrA));
    w_tailB = r_tail + PW'(w_wrA);
    w_free  = (PW+1)'(DEPTH) - r_count;
  end

  assign bus.OUT_uop   = w_out;
  assign bus.OUT_stall = w_free < (PW+1)'(2);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (r_mem[i].valid && younger(r_mem[i].sqN, bus.IN_branch)) r_mem[i].valid <= 1'b0;
      if (w_pop) r_mem[r_head].valid <= 1'b0;
      if (w_wrA) r_mem[r_tail]  <= bus.IN_uopA;
      if (w_wrB) r_mem[w_tailB] <= bus.IN_uopB;
      r_head  <= r_head + PW'(w_pop);
      r_tail  <= r_tail + PW'(w_wrA) + PW'(w_wrB);
      r_count <= r_count + (PW+1)'(w_wrA) + (PW+1)'(w_wrB) - (PW+1)'(w_pop);
    end
  end

  // Producers ignoring OUT_stall lose results here.
  always_ff @(posedge clk) begin
    if (rst) assert (!(w_reqA && !w_wrA) && !(w_reqB && !w_wrB));
  end
endmodule

// File: tb/tb_fp_result_queue.sv
// Self-checking bench for fp_result_queue: per-cycle vector table plus an ordering scoreboard.
module tb_fp_result_queue;
  import fp_result_queue_pkg::*;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  fp_result_queue_if q();
  fp_result_queue #(.DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(q));

  always #5 clk = ~clk;

  RES_UOp sb[$];

  typedef struct {
    logic av; logic [6:0] as;
    logic bv; logic [6:0] bs;
    logic rdy; logic bt; logic [6:0] bsq;
    logic ev; logic [6:0] es; logic est;
  } vec_t;
  vec_t vecs[$];

  function automatic RES_UOp mk(logic [6:0] sq);
    RES_UOp u;
    u.valid       = 1'b1;
    u.tagDst      = sq ^ 7'h0f;
    u.sqN         = sq;
    u.result      = 32'h40400000 + {25'd0, sq};
    u.flags       = sq[3:0];
    u.doNotCommit = sq[0];
    return u;
  endfunction

  function automatic logic young(logic [6:0] sq, BranchProv b);
    logic signed [6:0] d;
    d = sq - b.sqN;
    return b.taken && (d > 0);
  endfunction

  task automatic drive(input logic av, input logic [6:0] as, input logic bv, input logic [6:0] bs,
                       input logic rdy, input logic bt, input logic [6:0] bsq);
    BranchProv b;
    b.taken = bt;
    b.sqN   = bsq;
    q.IN_branch = b;
    q.IN_uopA   = av ? mk(as) : '0;
    q.IN_uopB   = bv ? mk(bs) : '0;
    q.IN_ready  = rdy;
    if (av && !young(as, b)) sb.push_back(mk(as));
    if (bv && !young(bs, b)) sb.push_back(mk(bs));
  endtask

  task automatic chk(input string nm, input logic ev, input logic [6:0] es, input logic est);
    tests++;
    if (q.OUT_uop.valid !== ev || q.OUT_stall !== est || (ev && q.OUT_uop.sqN !== es)) begin
      fails++;
      $display("FAIL %s: got valid=%b sqN=%0d stall=%b, required valid=%b sqN=%0d stall=%b",
               nm, q.OUT_uop.valid, q.OUT_uop.sqN, q.OUT_stall, ev, es, est);
    end
  endtask

  task automatic add(input logic av, input logic [6:0] as, input logic bv, input logic [6:0] bs,
                     input logic rdy, input logic bt, input logic [6:0] bsq,
                     input logic ev, input logic [6:0] es, input logic est);
    vec_t v;
    v = '{av, as, bv, bs, rdy, bt, bsq, ev, es, est};
    vecs.push_back(v);
  endtask

  // Scoreboard: every accepted output must be the oldest surviving pushed result.
  always @(negedge clk) begin
    if (rst) begin
      if (q.OUT_uop.valid && q.IN_ready) begin
        tests++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL sb_unexpected: got sqN=%0d, required no output", q.OUT_uop.sqN);
        end else begin
          RES_UOp e;
          e = sb.pop_front();
          if (q.OUT_uop !== e) begin
            fails++;
            $display("FAIL sb_order: got %h, required %h", q.OUT_uop, e);
          end
        end
      end
      if (q.IN_branch.taken)
        for (int i = sb.size() - 1; i >= 0; i--)
          if (young(sb[i].sqN, q.IN_branch)) sb.delete(i);
    end
  end

  initial begin
    #200000;
    fails++;
    $display("FAIL watchdog: got timeout, required completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1);
  end

  initial begin
    //  av as  bv bs rdy bt bsq  ev es  est
    add(1, 10, 0, 0, 1, 0, 0,   0, 0,  0);   // single result
    add(0, 0,  0, 0, 1, 0, 0,   1, 10, 0);
    add(0, 0,  0, 0, 1, 0, 0,   0, 0,  0);
    add(1, 3,  1, 4, 1, 0, 0,   0, 0,  0);   // collision
    add(0, 0,  0, 0, 1, 0, 0,   1, 3,  0);
    add(0, 0,  0, 0, 1, 0, 0,   1, 4,  0);
    add(1, 20, 0, 0, 0, 0, 0,   0, 0,  0);   // back-pressure
    add(1, 21, 0, 0, 0, 0, 0,   1, 20, 0);
    add(1, 22, 0, 0, 0, 0, 0,   1, 20, 0);
    add(0, 0,  0, 0, 0, 0, 0,   1, 20, 1);
    add(0, 0,  0, 0, 1, 0, 0,   1, 20, 1);
    add(0, 0,  0, 0, 1, 0, 0,   1, 21, 0);
    add(0, 0,  0, 0, 1, 0, 0,   1, 22, 0);
    add(0, 0,  0, 0, 1, 0, 0,   0, 0,  0);
    add(1, 7,  1, 9, 0, 0, 0,   0, 0,  0);   // squash
    add(1, 12, 0, 0, 0, 0, 0,   1, 7,  0);
    add(1, 11, 0, 0, 1, 1, 8,   1, 7,  1);
    add(0, 0,  0, 0, 1, 0, 0,   0, 0,  0);
    add(0, 0,  0, 0, 1, 0, 0,   0, 0,  0);
    add(0, 0,  0, 0, 1, 0, 0,   0, 0,  0);
    add(1, 30, 0, 0, 0, 0, 0,   0, 0,  0);   // branch kills presented head
    add(0, 0,  0, 0, 1, 1, 29,  0, 0,  0);
    add(0, 0,  0, 0, 1, 0, 0,   0, 0,  0);
    add(1, 31, 0, 0, 1, 0, 0,   0, 0,  0);
    add(0, 0,  0, 0, 1, 0, 0,   1, 31, 0);
    add(1, 2,  0, 0, 0, 0, 0,   0, 0,  0);   // sqN wrap: younger across 0
    add(0, 0,  0, 0, 1, 1, 125, 0, 0,  0);
    add(0, 0,  0, 0, 1, 0, 0,   0, 0,  0);
    add(1, 120,0, 0, 0, 0, 0,   0, 0,  0);   // sqN wrap: older across 0
    add(0, 0,  0, 0, 1, 1, 3,   1, 120,0);
    add(0, 0,  0, 0, 1, 0, 0,   0, 0,  0);

    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_state", 0, 0, 0);
    #2 rst = 1'b1;

    foreach (vecs[i]) begin
      @(posedge clk); #1;
      drive(vecs[i].av, vecs[i].as, vecs[i].bv, vecs[i].bs, vecs[i].rdy, vecs[i].bt, vecs[i].bsq);
      @(negedge clk);
      chk($sformatf("vec%0d", i), vecs[i].ev, vecs[i].es, vecs[i].est);
    end

    // Back-to-back stream: pointers wrap twice with no bubble.
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      drive(1, 7'(40 + k), 0, 0, 1, 0, 0);
      @(negedge clk);
      chk($sformatf("wrap%0d", k), k > 0, 7'(39 + k), 0);
    end
    @(posedge clk); #1; drive(0, 0, 0, 0, 1, 0, 0);
    @(negedge clk); chk("wrap_last", 1, 49, 0);
    @(posedge clk); #1; drive(0, 0, 0, 0, 1, 0, 0);
    @(negedge clk); chk("wrap_empty", 0, 0, 0);

    // Asynchronous reset with three entries in flight.
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      drive(1, 7'(50 + k), 0, 0, 0, 0, 0);
      @(negedge clk);
      chk($sformatf("prerst%0d", k), k > 0, 50, 0);
    end
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 0, 0);
    #1 chk("prerst_full", 1, 50, 1);
    #1 rst = 1'b0;
    #1 chk("rst_async", 0, 0, 0);
    sb.delete();
    @(negedge clk); #2 rst = 1'b1;
    @(posedge clk); #1; drive(1, 60, 0, 0, 1, 0, 0);
    @(negedge clk); chk("postrst_push", 0, 0, 0);
    @(posedge clk); #1; drive(0, 0, 0, 0, 1, 0, 0);
    @(negedge clk); chk("postrst_out", 1, 60, 0);
    @(posedge clk); #1; drive(0, 0, 0, 0, 1, 0, 0);
    @(negedge clk); chk("postrst_empty", 0, 0, 0);

    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL sb_leftover: got %0d pending, required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
